// File: rtl/shift_exec_unit.sv
// RV64I shift execute stage (SLL/SRL/SRA and W forms): right shifts reuse a left barrel shifter via bit reversal.
// Latency 2 cycles, full throughput; out_ready low stalls S2 then S1, and in_ready drops only when both are full.

module sll #(
    parameter int W  = 64,
    parameter int SW = 6
) (
    input  logic [W-1:0]  i_data,
    input  logic [SW-1:0] i_shamt,
    output logic [W-1:0]  o_data
);
    logic [W-1:0] w_stage [SW+1];

    assign w_stage[0] = i_data;

    for (genvar g = 0; g < SW; g++) begin : g_stage
        assign w_stage[g+1] = i_shamt[g] ? (w_stage[g] << (1 << g)) : w_stage[g];
    end

    assign o_data = w_stage[SW];
endmodule

module shift_exec_unit #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [5:0]       in_shamt,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);
    localparam int HALF = XLEN / 2;
    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_RSV = 2'b10;
    localparam logic [1:0] OP_SRA = 2'b11;

    function automatic logic [XLEN-1:0] bitrev(input logic [XLEN-1:0] x);
        logic [XLEN-1:0] r;
        for (int i = 0; i < XLEN; i++) begin
            r[i] = x[XLEN-1-i];
        end
        return r;
    endfunction

    logic             r_s1_valid;
    logic [2:0]       r_s1_op;
    logic [TAG_W-1:0] r_s1_tag;
    logic [5:0]       r_s1_sh;
    logic [XLEN-1:0]  r_s1_opnd;
    logic             r_s1_sign;

    logic             r_out_valid;
    logic [XLEN-1:0]  r_out_data;
    logic [TAG_W-1:0] r_out_tag;
    logic             r_out_illegal;

    logic             w_s2_advance;
    logic             w_in_fire;
    logic             w_s1_move;
    logic [5:0]       w_in_sh;
    logic [XLEN-1:0]  w_in_opnd;
    logic             w_right;
    logic [XLEN-1:0]  w_sh_in;
    logic [XLEN-1:0]  w_sh_out;
    logic [XLEN-1:0]  w_result;
    logic             w_illegal;

    assign w_s2_advance = !r_out_valid || out_ready;
    assign in_ready     = !r_s1_valid || w_s2_advance;
    assign w_in_fire    = in_valid && in_ready;
    assign w_s1_move    = r_s1_valid && w_s2_advance;

    // W forms shift only the low word; SRAW pre-extends so the right shift pulls in copies of bit 31.
    always_comb begin
        w_in_sh   = in_shamt;
        w_in_opnd = in_rs1;
        if (in_op[2]) begin
            w_in_sh = {1'b0, in_shamt[4:0]};
            if (in_op[1:0] == OP_SRA) begin
                w_in_opnd = {{HALF{in_rs1[HALF-1]}}, in_rs1[HALF-1:0]};
            end else begin
                w_in_opnd = {{HALF{1'b0}}, in_rs1[HALF-1:0]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= '0;
            r_s1_tag   <= '0;
            r_s1_sh    <= '0;
            r_s1_opnd  <= '0;
            r_s1_sign  <= 1'b0;
        end else begin
            if (w_in_fire) begin
                r_s1_valid <= 1'b1;
                r_s1_op    <= in_op;
                r_s1_tag   <= in_tag;
                r_s1_sh    <= w_in_sh;
                r_s1_opnd  <= w_in_opnd;
                r_s1_sign  <= w_in_opnd[XLEN-1];
            end else if (w_s1_move) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    assign w_right = (r_s1_op[1:0] == OP_SRL) || (r_s1_op[1:0] == OP_SRA);
    assign w_sh_in = w_right ? bitrev(r_s1_opnd) : r_s1_opnd;

    sll #(.W(XLEN), .SW(6)) u_sll (
        .i_data  (w_sh_in),
        .i_shamt (r_s1_sh),
        .o_data  (w_sh_out)
    );

    always_comb begin
        w_illegal = (r_s1_op[1:0] == OP_RSV);
        w_result  = w_right ? bitrev(w_sh_out) : w_sh_out;
        if ((r_s1_op[1:0] == OP_SRA) && r_s1_sign) begin
            w_result = w_result | ~({XLEN{1'b1}} >> r_s1_sh);
        end
        if (r_s1_op[2]) begin
            w_result = {{HALF{w_result[HALF-1]}}, w_result[HALF-1:0]};
        end
        if (w_illegal) begin
            w_result = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_out_tag     <= '0;
            r_out_illegal <= 1'b0;
        end else begin
            if (w_s1_move) begin
                r_out_valid   <= 1'b1;
                r_out_data    <= w_result;
                r_out_tag     <= r_s1_tag;
                r_out_illegal <= w_illegal;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign out_tag     = r_out_tag;
    assign out_illegal = r_out_illegal;
endmodule

// File: doc/shift_exec_unit.md
Name: shift_exec_unit

Overview:
- Pipelined RV64I shift execute stage: SLL, SRL, SRA, SLLW, SRLW and SRAW.
- Sits between issue/operand-read and writeback. It decodes the shift op, conditions the operand, drives an internal instance of the existing left barrel shifter `sll`, and post-processes the result.
- Right shifts are done by bit reversal around the left shifter. Arithmetic fill and W-form sign extension are applied afterwards.
- Valid/ready handshakes on both sides; 2-cycle latency; full throughput.

Parameters:
- XLEN, 64, datapath width; must be 64 (W forms use the low 32 bits).
- TAG_W, 5, width of the destination register tag carried alongside the data.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream request valid.
- in_ready  output  1  unit can accept a request this cycle.
- in_op  input  3  bit2 = W form; bits1:0 = 00 SLL, 01 SRL, 11 SRA, 10 reserved.
- in_rs1  input  XLEN  value to shift.
- in_shamt  input  6  shift amount (rs2[5:0] or imm).
- in_tag  input  TAG_W  destination tag.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  XLEN  shift result.
- out_tag  output  TAG_W  tag of out_data.
- out_illegal  output  1  op was reserved; out_data = 0.

Behaviour:
- Reset (async, while rst_n = 0): s1_valid = 0, out_valid = 0, out_data = 0, out_tag = 0, out_illegal = 0, all stage-1 registers = 0. in_ready reads 1 once reset is released.
- Transfers: a transfer occurs on a rising edge where valid && ready on that side.
- Stage 1 (S1) registers, loaded on an input transfer:
  - op, tag, effective amount: sh = W ? {0, shamt[4:0]} : shamt[5:0].
  - Conditioned operand: SLLW/SRLW use {32'b0, rs1[31:0]}; SRAW uses {32{rs1[31]}, rs1[31:0]}; 64-bit forms use rs1 unchanged.
  - Sign bit: operand[63], stored as shifted in.
- Between S1 and S2 (combinational):
  - Left shifts feed the operand to `sll`.
  - Right shifts feed bit-reverse(operand) and reverse the shifter output.
  - SRA/SRAW: result |= ~(all-ones >> sh) when the sign bit = 1.
  - W forms: result = sign-extend(result[31:0]).
  - Reserved op: result = 0, illegal = 1.
- Stage 2 = output registers out_data, out_tag, out_illegal, out_valid.
- Latency: an input transfer at edge k gives out_valid at edge k+2 if not stalled.
- Stall rules:
  - s2_advance = !out_valid || out_ready.
  - s1 advances into S2 when s1_valid && s2_advance.
  - in_ready = !s1_valid || s2_advance (combinational; no path from in_valid).
- Output holding: while out_valid && !out_ready, out_data/out_tag/out_illegal are held stable. S1 holds its contents; nothing is dropped or duplicated.
- out_valid drop: clears on an output transfer unless S1 supplies a new result in the same edge.
- Simultaneous events: an output transfer, S1→S2 move and new input acceptance can all happen on one edge, giving back-to-back throughput of one result per cycle.
- Amount boundaries:
  - sh = 0 returns the operand; W forms are still sign-extended.
  - sh = 63 (64-bit) and sh = 31 (W) are legal.
  - in_shamt[5] is ignored for W forms.
- Reset mid-operation: all in-flight entries are discarded immediately and out_valid falls asynchronously. No result is emitted after reset is released.
- Ordering: results leave in acceptance order.

Test Plan:
- SLL: rs1 = 0x0000_0000_0000_0001, shamt = 63 -> out_data = 0x8000_0000_0000_0000, arriving 2 cycles after acceptance.
- SRA vs SRL: rs1 = 0x8000_0000_0000_0000, shamt = 4 -> SRA gives 0xF800_0000_0000_0000; SRL gives 0x0800_0000_0000_0000.
- W forms:
  - SLLW rs1 = 0x0000_0000_4000_0000, shamt = 1 -> 0xFFFF_FFFF_8000_0000.
  - SRAW rs1 = 0x1234_5678_8000_0000, shamt = 33 (uses 1) -> 0xFFFF_FFFF_C000_0000.
  - SRLW same operands -> 0x0000_0000_4000_0000.
- Backpressure: stream 4 ops with tags 1..4 while out_ready = 0 for 5 cycles -> in_ready falls after 2 accepts. out_data/out_tag stay stable at tag 1. On release, tags 1..4 emerge in order on consecutive cycles.
- Reserved op in_op = 3'b010 -> out_data = 0, out_illegal = 1, tag passed through. The following valid op has out_illegal = 0.
- Assert rst_n = 0 asynchronously with 2 entries in flight -> out_valid = 0 before the next edge. No stale result after reset is released; in_ready = 1.
